// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. One operand set (a, b, bin) is accepted per
// transaction. The difference is then formed one bit per clock, LSB first,
// through a single-bit full subtractor. The result (diff, bout) is presented
// until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Input side: in_valid/in_ready, where in_ready is high only when idle.
// Output side: out_valid/out_ready. diff and bout are held stable while
// out_valid && !out_ready.
//
// Parameters:
//   WIDTH      operand/result width in bits, 2..64
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set present on a/b/bin
//   in_ready   block idle, operands accepted on this edge if in_valid
//   a          minuend (unsigned)
//   b          subtrahend (unsigned)
//   bin        borrow-in
//   out_valid  diff/bout valid
//   out_ready  consumer accepts the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       borrow-out, 1 when a < b + bin
//   busy       high while bits are being processed
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] a_sh_q,      a_sh_d;
   logic [WIDTH-1:0] b_sh_q,      b_sh_d;
   logic             br_q,        br_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] diff_q,      diff_d;
   logic             bout_q,      bout_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;

   // Single-bit full subtractor on the current LSBs and the running borrow.
   logic a0, b0, d_bit, br_next;

   always_comb begin
      a0      = a_sh_q[0];
      b0      = b_sh_q[0];
      d_bit   = a0 ^ b0 ^ br_q;
      br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         ST_IDLE: begin
            // in_ready is high exactly in this state, so in_valid alone
            // completes the input handshake.
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            br_d   = br_next;
            // New bits enter at the MSB end. After WIDTH shifts, the first
            // (LSB) result bit has walked down to position 0.
            diff_d = {d_bit, diff_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               bout_d  = br_next;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // Returning to IDLE here means no new operand can be taken on
            // the same edge that the result is consumed.
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next state, so each is
      // exactly aligned with the state it reports.
      in_ready_d  = (state_d == ST_IDLE);
      busy_d      = (state_d == ST_SHIFT);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         br_q        <= 1'b0;
         cnt_q       <= '0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         br_q        <= br_d;
         cnt_q       <= cnt_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor at WIDTH = 8. Each transaction's
// expected diff/bout are worked out by hand from the operands. Outputs are
// sampled 1 time unit after the rising clock edge, and inputs are changed at
// the same point.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W       = 8;
   localparam int MAX_LAT = 40;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;

   int tests_run = 0;
   int tests_failed = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .busy      (busy)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // --------------------------------------------------------------- checker
   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid, bounded. Also count the samples that show busy.
   task automatic wait_valid(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!out_valid && lat < MAX_LAT) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
   endtask

   // Full transaction. The caller must be at a non-edge time with the DUT
   // idle. hold = number of extra edges out_ready stays low in DONE.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] exp_diff, input logic exp_bout,
                        input int hold, input string tag);
      int lat;
      int bcnt;
      a         = ta;
      b         = tb_v;
      bin       = tbin;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      chk(in_ready, 1, {tag, ".in_ready_before"});
      step();
      in_valid = 1'b0;
      chk(busy, 1, {tag, ".busy_after_accept"});
      wait_valid(lat, bcnt);
      chk(lat, W, {tag, ".latency"});
      chk(bcnt, W, {tag, ".busy_cycles"});
      chk(diff, exp_diff, {tag, ".diff"});
      chk(bout, exp_bout, {tag, ".bout"});
      chk(in_ready, 0, {tag, ".in_ready_done"});
      for (int h = 0; h < hold; h++) begin
         step();
         chk(out_valid, 1, {tag, ".hold_valid"});
         chk(diff, exp_diff, {tag, ".hold_diff"});
         chk(bout, exp_bout, {tag, ".hold_bout"});
         chk(in_ready, 0, {tag, ".hold_in_ready"});
      end
      out_ready = 1'b1;
      step();
      chk(out_valid, 0, {tag, ".valid_cleared"});
      chk(in_ready, 1, {tag, ".back_idle"});
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int lat;
      int bcnt;
      int seen_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      out_ready = 1'b0;

      // Reset values
      step();
      step();
      chk(in_ready, 1, "reset.in_ready");
      chk(out_valid, 0, "reset.out_valid");
      chk(busy, 0, "reset.busy");
      chk(diff, 8'h00, "reset.diff");
      chk(bout, 0, "reset.bout");

      // Accept on the first edge after reset deasserts
      @(negedge clk);
      rst = 1'b0;
      do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, "basic");

      // Underflow cases
      do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, "under_0m1");
      do_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 0, "under_eq_bin");
      do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0, "under_0mffm1");
      do_op(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 0, "under_7f_80");

      // Borrow-in chain and no-borrow boundary
      do_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, "chain_80_7f");
      do_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 0, "chain_ff_00");

      // Backpressure: out_ready low for 5 edges in DONE
      do_op(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 5, "backpressure");

      // Busy-ignore: in_valid held high with new operands during SHIFT
      a         = 8'h05;
      b         = 8'h03;
      bin       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      a   = 8'hAA;
      b   = 8'h11;
      bin = 1'b1;
      wait_valid(lat, bcnt);
      chk(lat, W, "ignore.first_latency");
      chk(diff, 8'h02, "ignore.first_diff");
      chk(bout, 0, "ignore.first_bout");
      step();
      chk(in_ready, 1, "ignore.idle_no_accept");
      chk(busy, 0, "ignore.not_busy_on_release");
      step();
      in_valid = 1'b0;
      chk(busy, 1, "ignore.second_accepted");
      wait_valid(lat, bcnt);
      chk(lat, W, "ignore.second_latency");
      chk(diff, 8'h98, "ignore.second_diff");
      chk(bout, 0, "ignore.second_bout");
      step();
      chk(in_ready, 1, "ignore.second_idle");

      // Reset in the middle of SHIFT, after 4 bits are processed
      a        = 8'h37;
      b        = 8'h12;
      bin      = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk(busy, 1, "midrst.busy_before");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk(in_ready, 1, "midrst.in_ready");
      chk(busy, 0, "midrst.busy");
      chk(out_valid, 0, "midrst.out_valid");
      chk(diff, 8'h00, "midrst.diff");
      chk(bout, 0, "midrst.bout");
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (out_valid || busy) seen_valid++;
      end
      chk(seen_valid, 0, "midrst.no_result");
      do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/bin present.
REQ-005 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  diff/bout valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow-out, 1 when a - b - bin < 0.
REQ-013 SHALL have port busy  output  1  high in SHIFT state.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; encoding implementer's choice.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 only in SHIFT.
REQ-016 SHALL accept operands on a rising edge where in_valid && in_ready: capture a, b into shift registers, bin into borrow flop, clear bit counter, go to SHIFT.
REQ-017 SHALL in SHIFT process one bit per cycle, LSB first, via a single-bit full subtractor: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-018 SHALL shift each d into the result register MSB end so that after WIDTH SHIFT cycles diff holds bit i at position i.
REQ-019 SHALL remain in SHIFT exactly WIDTH cycles; counter at WIDTH-1 on last bit, then go to DONE; out_valid rises on edge WIDTH after the accept edge.
REQ-020 SHALL on entering DONE present diff and bout = final borrow; both held stable while out_valid && !out_ready.
REQ-021 SHALL on a rising edge with out_valid && out_ready go to IDLE; no new operand accepted on that same edge.
REQ-022 SHALL ignore in_valid, a, b, bin while not in IDLE; operands need only be stable on the accept edge.
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL give minimum accept-to-accept spacing of WIDTH+2 cycles with out_ready held high.
REQ-025 SHALL leave diff undefined-but-unused outside DONE; verification checks diff/bout only when out_valid = 1.
REQ-026 SHALL produce bout = 1 exactly when unsigned a < b + bin, including a = b, bin = 1 case.

Reset
REQ-027 SHALL on rst high, asynchronously, force state IDLE, in_ready = 1, out_valid = 0, busy = 0, diff = 0, bout = 0, counter = 0, shift/borrow registers = 0.
REQ-028 SHALL abandon any in-progress operation on rst (SHIFT or DONE) with no result emitted afterward.
REQ-029 SHALL accept operands on the first rising edge after rst deasserts if in_valid = 1.

Verification
REQ-030 SHALL cover basic: WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1 -> out_valid 8 cycles after accept, diff=0x02, bout=0, busy high exactly 8 cycles.
REQ-031 SHALL cover underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x05, b=0x05, bin=1 -> diff=0xFF, bout=1.
REQ-032 SHALL cover borrow-in chain: a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
REQ-033 SHALL cover backpressure: out_ready low 5 cycles in DONE -> out_valid, diff, bout stable, in_ready=0; out_ready high -> IDLE next edge, in_ready=1.
REQ-034 SHALL cover busy-ignore: in_valid=1 with new operands throughout SHIFT -> first result unaffected, second operand set accepted only once IDLE.
REQ-035 SHALL cover reset mid-SHIFT: rst asserted at bit 4 -> outputs immediately at reset values, no out_valid; next op a=0x10, b=0x01 -> diff=0x0F, bout=0.
